// File: rtl/ps_stage_param_pkg.sv
// Shared field widths, ABSORB opcode and PS parity helper for the PS stage and its neighbours.
package ps_stage_param_pkg;

    localparam int CG_W_DEF       = 11;
    localparam int DEST_W_DEF     = 7;
    localparam int CZDD_W_DEF     = 34;
    localparam int NDEST_W_DEF    = 7;
    localparam int FLAG_W_DEF     = 4;
    localparam int OPC_W_DEF      = 6;
    localparam int OBUF_DEPTH_DEF = 3;
    localparam int ABSORB_DEF     = 'h3F;

    localparam int ABS_CNT_W = 16;
    typedef logic [ABS_CNT_W-1:0] abs_cnt_t;
    localparam abs_cnt_t ABS_CNT_MAX = '1;

    // Even parity bit: stored bit plus data always has an even number of ones.
    function automatic logic even_par(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ps_stage_param_obuf_fifo.sv
// Output buffer of the PS stage: DEPTH x W register FIFO with count, full and empty.
// Head reads as zero while empty so the packet bus is clean after reset.
module ps_obuf_fifo
    import ps_stage_param_pkg::*;
#(
    parameter int DEPTH = OBUF_DEPTH_DEF,
    parameter int W     = 62,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(DEPTH));
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
        count = count_q;
        dout  = empty ? '0 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ps_stage_param.sv
// Parametrised program-storage stage: reads the PS word at DEST and emits {CG, PS word, CZDD}.
// Build option DDP_PS_PARITY_EN adds an even-parity bit per PS word and a sticky PAR_ERR.
module ps_stage_param
    import ps_stage_param_pkg::*;
#(
    parameter int              CG_W       = CG_W_DEF,
    parameter int              DEST_W     = DEST_W_DEF,
    parameter int              CZDD_W     = CZDD_W_DEF,
    parameter int              NDEST_W    = NDEST_W_DEF,
    parameter int              FLAG_W     = FLAG_W_DEF,
    parameter int              OPC_W      = OPC_W_DEF,
    parameter int              OBUF_DEPTH = OBUF_DEPTH_DEF,
    parameter logic [OPC_W-1:0] ABSORB    = OPC_W'(ABSORB_DEF)
) (
    input  logic                                      CP,
    input  logic                                      MR,
    input  logic                                      Send_in,
    output logic                                      Ack_out,
    input  logic [CG_W+DEST_W+CZDD_W-1:0]             PACKET_IN,
    output logic                                      Send_out,
    input  logic                                      Ack_in,
    output logic [CG_W+NDEST_W+FLAG_W+OPC_W+CZDD_W-1:0] PACKET_OUT,
    output logic                                      DEL,
    input  logic                                      PS_WE,
    input  logic [DEST_W-1:0]                         PS_WADDR,
    input  logic [NDEST_W+FLAG_W+OPC_W-1:0]           PS_WDATA,
    output logic [15:0]                               ABS_CNT,
    output logic                                      PAR_ERR
);

    localparam int PSW_W    = NDEST_W + FLAG_W + OPC_W;
    localparam int IN_W     = CG_W + DEST_W + CZDD_W;
    localparam int OUT_W    = CG_W + PSW_W + CZDD_W;
    localparam int PS_DEPTH = 2 ** DEST_W;
    localparam int CNT_W    = $clog2(OBUF_DEPTH + 1);
`ifdef DDP_PS_PARITY_EN
    localparam int PSM_W    = PSW_W + 1;
`else
    localparam int PSM_W    = PSW_W;
`endif

    logic [PSM_W-1:0]  ps_mem [PS_DEPTH];
    logic [PSM_W-1:0]  ps_rd_q;
    logic [PSM_W-1:0]  ps_wword;
    logic [DEST_W-1:0] in_dest;

    logic              s1_v_q, s1_v_d;
    logic [CG_W-1:0]   s1_cg_q, s1_cg_d;
    logic [CZDD_W-1:0] s1_czdd_q, s1_czdd_d;
    logic              del_q, del_d;
    abs_cnt_t          abs_cnt_q, abs_cnt_d;

    logic              in_xfer;
    logic              par_bad;
    logic              absorb;
    logic              push;
    logic              pop;
    logic [PSW_W-1:0]  s1_psw;
    logic [OPC_W-1:0]  s1_opc;
    logic [OUT_W-1:0]  push_data;
    logic [CNT_W-1:0]  ob_count;
    logic              ob_full;
    logic              ob_empty;
    logic [CNT_W:0]    inflight;

`ifdef DDP_PS_PARITY_EN
    logic              par_err_q, par_err_d;

    assign ps_wword = {even_par(64'(PS_WDATA)), PS_WDATA};
    assign par_bad  = ^ps_rd_q;
    assign PAR_ERR  = par_err_q;

    always_comb begin
        par_err_d = par_err_q | (s1_v_q & par_bad);
    end

    always_ff @(posedge CP) begin
        if (MR) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end
`else
    assign ps_wword = PS_WDATA;
    assign par_bad  = 1'b0;
    assign PAR_ERR  = 1'b0;
`endif

    // Ready depends only on state, so the upstream never sees a path from Ack_in.
    always_comb begin
        inflight = {1'b0, ob_count} + {{CNT_W{1'b0}}, s1_v_q};
        Ack_out  = !ob_full && (inflight <= (CNT_W+1)'(OBUF_DEPTH - 1));
        in_xfer  = Send_in && Ack_out;
        in_dest  = PACKET_IN[CZDD_W +: DEST_W];
    end

    // PS is program state: untouched by MR, and the load port runs regardless of handshake.
    always_ff @(posedge CP) begin
        if (PS_WE) begin
            ps_mem[PS_WADDR] <= ps_wword;
        end
        if (in_xfer) begin
            ps_rd_q <= ps_mem[in_dest];
        end
    end

    always_comb begin
        s1_v_d    = in_xfer;
        s1_cg_d   = in_xfer ? PACKET_IN[IN_W-1 -: CG_W] : s1_cg_q;
        s1_czdd_d = in_xfer ? PACKET_IN[CZDD_W-1:0] : s1_czdd_q;

        s1_psw    = ps_rd_q[PSW_W-1:0];
        s1_opc    = s1_psw[OPC_W-1:0];
        absorb    = s1_v_q && ((s1_opc == ABSORB) || par_bad);
        push      = s1_v_q && !absorb;
        push_data = {s1_cg_q, s1_psw, s1_czdd_q};

        del_d     = !absorb;
        abs_cnt_d = abs_cnt_q;
        if (absorb && (abs_cnt_q != ABS_CNT_MAX)) begin
            abs_cnt_d = abs_cnt_q + abs_cnt_t'(1);
        end
    end

    always_ff @(posedge CP) begin
        if (MR) begin
            s1_v_q    <= 1'b0;
            s1_cg_q   <= '0;
            s1_czdd_q <= '0;
            del_q     <= 1'b1;
            abs_cnt_q <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_cg_q   <= s1_cg_d;
            s1_czdd_q <= s1_czdd_d;
            del_q     <= del_d;
            abs_cnt_q <= abs_cnt_d;
        end
    end

    assign pop      = Send_out && Ack_in;
    assign Send_out = !ob_empty;
    assign DEL      = del_q;
    assign ABS_CNT  = abs_cnt_q;

    ps_obuf_fifo #(
        .DEPTH (OBUF_DEPTH),
        .W     (OUT_W),
        .CNT_W (CNT_W)
    ) u_obuf (
        .clk   (CP),
        .rst   (MR),
        .push  (push),
        .pop   (pop),
        .din   (push_data),
        .dout  (PACKET_OUT),
        .count (ob_count),
        .full  (ob_full),
        .empty (ob_empty)
    );

endmodule

// File: tb/tb_ps_stage_param.sv
// Directed bench for ps_stage_param: vector table for single packets plus hand sequences for
// absorb, backpressure, read-first PS update, mid-flight reset and (with DDP_PS_PARITY_EN) parity.
module tb_ps_stage_param;

    localparam int IN_W  = 52;
    localparam int OUT_W = 62;

    localparam logic [16:0] W5   = {7'd9,   4'b0011, 6'h01};
    localparam logic [16:0] W7   = {7'd0,   4'b0000, 6'h3F};
    localparam logic [16:0] W0   = {7'd0,   4'b1000, 6'h00};
    localparam logic [16:0] W10  = {7'd127, 4'b1111, 6'h3E};
    localparam logic [16:0] W127 = {7'd1,   4'b0101, 6'h2A};
    localparam logic [16:0] W1   = {7'd33,  4'b0110, 6'h05};
    localparam logic [16:0] W2   = {7'd66,  4'b1001, 6'h0A};
    localparam logic [16:0] W9   = {7'd100, 4'b0001, 6'h11};
    localparam logic [16:0] W4   = {7'd4,   4'b0100, 6'h04};

    logic              CP = 1'b0;
    logic              MR;
    logic              Send_in;
    logic              Ack_out;
    logic [IN_W-1:0]   PACKET_IN;
    logic              Send_out;
    logic              Ack_in;
    logic [OUT_W-1:0]  PACKET_OUT;
    logic              DEL;
    logic              PS_WE;
    logic [6:0]        PS_WADDR;
    logic [16:0]       PS_WDATA;
    logic [15:0]       ABS_CNT;
    logic              PAR_ERR;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [6:0]  dest;
        logic [10:0] cg;
        logic [33:0] czdd;
        logic [61:0] exp;
    } vec_t;

    vec_t vecs [5];

    always #5 CP = ~CP;

    ps_stage_param dut (
        .CP         (CP),
        .MR         (MR),
        .Send_in    (Send_in),
        .Ack_out    (Ack_out),
        .PACKET_IN  (PACKET_IN),
        .Send_out   (Send_out),
        .Ack_in     (Ack_in),
        .PACKET_OUT (PACKET_OUT),
        .DEL        (DEL),
        .PS_WE      (PS_WE),
        .PS_WADDR   (PS_WADDR),
        .PS_WDATA   (PS_WDATA),
        .ABS_CNT    (ABS_CNT),
        .PAR_ERR    (PAR_ERR)
    );

    task automatic step();
        @(posedge CP);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ps_write(input logic [6:0] addr, input logic [16:0] data);
        PS_WE    = 1'b1;
        PS_WADDR = addr;
        PS_WDATA = data;
        step();
        PS_WE    = 1'b0;
    endtask

    function automatic logic [61:0] t3_exp(input int j);
        return {11'(11'h100 + j), W5, 34'(34'h300 + j)};
    endfunction

    function automatic logic [51:0] t3_pkt(input int j);
        return {11'(11'h100 + j), 7'd5, 34'(34'h300 + j)};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  idx;
        int  rx;
        logic acc;
        logic head_ok;

        vecs[0] = '{7'd5,   11'h2A5, 34'h1234,        {11'h2A5, W5,   34'h1234}};
        vecs[1] = '{7'd0,   11'h000, 34'h0,           {11'h000, W0,   34'h0}};
        vecs[2] = '{7'd127, 11'h7FF, 34'h3_FFFF_FFFF, {11'h7FF, W127, 34'h3_FFFF_FFFF}};
        vecs[3] = '{7'd10,  11'h155, 34'h2_AAAA_AAAA, {11'h155, W10,  34'h2_AAAA_AAAA}};
        vecs[4] = '{7'd5,   11'h001, 34'h1_0000_0001, {11'h001, W5,   34'h1_0000_0001}};

        MR = 1'b1; Send_in = 1'b0; Ack_in = 1'b1; PACKET_IN = '0;
        PS_WE = 1'b0; PS_WADDR = '0; PS_WDATA = '0;
        step();
        step();
        // programming happens with MR still asserted
        ps_write(7'd5, W5);
        ps_write(7'd7, W7);
        ps_write(7'd0, W0);
        ps_write(7'd10, W10);
        ps_write(7'd127, W127);
        ps_write(7'd3, W1);
        MR = 1'b0;
        step();

        check("rst_ack_out", Ack_out, 1);
        check("rst_send_out", Send_out, 0);
        check("rst_packet_out", PACKET_OUT, 0);
        check("rst_del", DEL, 1);
        check("rst_abs_cnt", ABS_CNT, 0);
        check("rst_par_err", PAR_ERR, 0);

        for (int i = 0; i < 5; i++) begin
            Send_in   = 1'b1;
            PACKET_IN = {vecs[i].cg, vecs[i].dest, vecs[i].czdd};
            step();
            Send_in   = 1'b0;
            PACKET_IN = '0;
            check($sformatf("vec%0d_early", i), Send_out, 0);
            step();
            check($sformatf("vec%0d_send_out", i), Send_out, 1);
            check($sformatf("vec%0d_packet", i), PACKET_OUT, vecs[i].exp);
            check($sformatf("vec%0d_del", i), DEL, 1);
            step();
            check($sformatf("vec%0d_one_beat", i), Send_out, 0);
        end

        // absorb
        Send_in   = 1'b1;
        PACKET_IN = {11'h3C3, 7'd7, 34'h5555};
        step();
        Send_in   = 1'b0;
        check("t2_del_before", DEL, 1);
        step();
        check("t2_del_low", DEL, 0);
        check("t2_no_send", Send_out, 0);
        check("t2_abs_cnt", ABS_CNT, 1);
        step();
        check("t2_del_back", DEL, 1);
        check("t2_still_no_send", Send_out, 0);

        // backpressure then drain
        Ack_in  = 1'b0;
        idx     = 0;
        head_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            Send_in   = 1'b1;
            PACKET_IN = t3_pkt(idx);
            acc       = Ack_out;
            step();
            if (acc) idx++;
            if (Send_out && (PACKET_OUT !== t3_exp(0))) head_ok = 1'b0;
        end
        check("t3_accepted", idx, 3);
        check("t3_ack_out_low", Ack_out, 0);
        check("t3_send_out", Send_out, 1);
        check("t3_head", PACKET_OUT, t3_exp(0));
        check("t3_head_stable", head_ok, 1);

        Ack_in = 1'b1;
        rx     = 0;
        for (int c = 0; c < 40 && rx < 10; c++) begin
            Send_in   = (idx < 10);
            PACKET_IN = t3_pkt(idx);
            acc       = Send_in && Ack_out;
            if (Send_out) begin
                check($sformatf("t3_rx%0d", rx), PACKET_OUT, t3_exp(rx));
                rx++;
            end
            step();
            if (acc) idx++;
        end
        Send_in = 1'b0;
        check("t3_rx_count", rx, 10);
        check("t3_tx_count", idx, 10);
        step();
        step();
        check("t3_no_dup", Send_out, 0);

        // read-first PS update
        Send_in   = 1'b1;
        PACKET_IN = {11'h0AA, 7'd3, 34'hA1};
        PS_WE     = 1'b1;
        PS_WADDR  = 7'd3;
        PS_WDATA  = W2;
        step();
        PS_WE     = 1'b0;
        PACKET_IN = {11'h0BB, 7'd3, 34'hB2};
        step();
        Send_in   = 1'b0;
        check("t4_old_word", PACKET_OUT, {11'h0AA, W1, 34'hA1});
        step();
        check("t4_new_word", PACKET_OUT, {11'h0BB, W2, 34'hB2});
        step();
        check("t4_drained", Send_out, 0);

        // reset mid-flight, PS load during reset
        Ack_in    = 1'b0;
        Send_in   = 1'b1;
        PACKET_IN = {11'h011, 7'd5, 34'h11};
        step();
        PACKET_IN = {11'h022, 7'd5, 34'h22};
        step();
        Send_in   = 1'b0;
        step();
        check("t5_full_before", Send_out, 1);
        MR       = 1'b1;
        PS_WE    = 1'b1;
        PS_WADDR = 7'd9;
        PS_WDATA = W9;
        step();
        PS_WE    = 1'b0;
        check("t5_send_out", Send_out, 0);
        check("t5_ack_out", Ack_out, 1);
        check("t5_packet_out", PACKET_OUT, 0);
        check("t5_abs_cnt", ABS_CNT, 0);
        check("t5_del", DEL, 1);
        MR     = 1'b0;
        Ack_in = 1'b1;
        step();
        check("t5_flushed", Send_out, 0);
        Send_in   = 1'b1;
        PACKET_IN = {11'h033, 7'd5, 34'h33};
        step();
        Send_in   = 1'b0;
        step();
        check("t5_ps_intact", PACKET_OUT, {11'h033, W5, 34'h33});
        step();
        Send_in   = 1'b1;
        PACKET_IN = {11'h044, 7'd9, 34'h44};
        step();
        Send_in   = 1'b0;
        step();
        check("t5_ps_write_in_reset", PACKET_OUT, {11'h044, W9, 34'h44});
        step();

`ifdef DDP_PS_PARITY_EN
        ps_write(7'd4, W4);
        dut.ps_mem[4] = dut.ps_mem[4] ^ 18'h2_0000;
        Send_in   = 1'b1;
        PACKET_IN = {11'h055, 7'd4, 34'h55};
        step();
        Send_in   = 1'b0;
        step();
        check("t6_par_err", PAR_ERR, 1);
        check("t6_del", DEL, 0);
        check("t6_dropped", Send_out, 0);
        check("t6_abs_cnt", ABS_CNT, 1);
        step();
        step();
        check("t6_par_err_sticky", PAR_ERR, 1);
        check("t6_still_dropped", Send_out, 0);
`else
        check("par_err_tied", PAR_ERR, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
